timer_control: RTL

Host-side control and status front end for the two OPL2 timers. Decodes register writes to the timer registers (0x02, 0x03, 0x04) into init values, start enables and per-timer masks for the two timer instances. Consumes their overflow levels and latches rising edges into sticky status flags. Presents the OPL2 status byte and an active-low IRQ to the host bus.

---
 rtl/timer_control.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/timer_control.sv
// -----------------------------------------------------------------------------
// timer_control
//
// Host-side control/status front end for the two OPL2 timers.
//   - Decodes host writes to 0x02 (timer 1 init), 0x03 (timer 2 init) and
//     0x04 (IRQ reset / masks / start enables).
//   - Detects rising edges on the timers' overflow levels and latches them
//     into sticky flags ft1/ft2 unless the timer is masked.
//   - Presents status = {irq, ft1, ft2, 5'b00000} and an active-low IRQ.
//
// Ports:
//   clk             in   system clock, all logic on posedge
//   reset           in   synchronous active-high reset
//   write           in   register write strobe
//   address[7:0]    in   register address (sampled when write=1)
//   data[7:0]       in   register write data (sampled when write=1)
//   timer1_overflow in   overflow level from timer 1
//   timer2_overflow in   overflow level from timer 2
//   timer1_init     out  reload value for timer 1
//   timer2_init     out  reload value for timer 2
//   timer1_start    out  run enable for timer 1
//   timer2_start    out  run enable for timer 2
//   status[7:0]     out  {irq, ft1, ft2, 5'b00000}
//   irq_n           out  active-low interrupt request
//
// Configuration macro:
//   OPL_TIMER_IRQ_PIN_EN  defined   -> irq_n = ~(ft1 | ft2)
//                         undefined -> irq_n tied to 1 (host polls status)
//
// Timer width comes from REG_TIMER_WIDTH (opl.vh); defaults to 8 here when
// that header has not been included ahead of this file.
// -----------------------------------------------------------------------------
`ifndef REG_TIMER_WIDTH
`define REG_TIMER_WIDTH 8
`endif

module timer_control (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        write,
    input  logic [7:0]                  address,
    input  logic [7:0]                  data,
    input  logic                        timer1_overflow,
    input  logic                        timer2_overflow,
    output logic [`REG_TIMER_WIDTH-1:0] timer1_init,
    output logic [`REG_TIMER_WIDTH-1:0] timer2_init,
    output logic                        timer1_start,
    output logic                        timer2_start,
    output logic [7:0]                  status,
    output logic                        irq_n
);

    localparam int TIMER_W = `REG_TIMER_WIDTH;

    logic [TIMER_W-1:0] timer1_init_reg;
    logic [TIMER_W-1:0] timer2_init_reg;
    logic               timer1_start_reg;
    logic               timer2_start_reg;

    // Register 0x04 decode: bit 7 selects IRQ reset versus control update.
    logic irq_reset_wr;
    logic ctrl_wr;
    assign irq_reset_wr = write && (address == 8'h04) &&  data[7];
    assign ctrl_wr      = write && (address == 8'h04) && !data[7];

    // Per-timer vectors; index 0 is timer 1, index 1 is timer 2.
    logic [1:0] ov_in;
    logic [1:0] mask_wdata;
    logic [1:0] flag_vec;
    assign ov_in      = {timer2_overflow, timer1_overflow};
    assign mask_wdata = {data[5], data[6]};

    // Init and start registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer1_init_reg  <= '0;
            timer2_init_reg  <= '0;
            timer1_start_reg <= 1'b0;
            timer2_start_reg <= 1'b0;
        end else if (write) begin
            if (address == 8'h02) begin
                timer1_init_reg <= data[TIMER_W-1:0];
            end
            if (address == 8'h03) begin
                timer2_init_reg <= data[TIMER_W-1:0];
            end
            if (ctrl_wr) begin
                timer1_start_reg <= data[0];
                timer2_start_reg <= data[1];
            end
        end
    end

    // Edge detector, mask and sticky flag for each timer.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_timer
            logic ov_q_reg;
            logic mask_reg;
            logic flag_reg;
            logic rise;

            assign rise = ov_in[gi] & ~ov_q_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    // Previous level reset high: an overflow already present
                    // when reset releases must not look like a fresh edge.
                    ov_q_reg <= 1'b1;
                    mask_reg <= 1'b0;
                    flag_reg <= 1'b0;
                end else begin
                    ov_q_reg <= ov_in[gi];
                    // The mask in force before this edge gates the rise; a
                    // same-cycle set beats an IRQ reset so no event is lost.
                    if (rise && !mask_reg) begin
                        flag_reg <= 1'b1;
                    end else if (irq_reset_wr) begin
                        flag_reg <= 1'b0;
                    end
                    if (ctrl_wr) begin
                        mask_reg <= mask_wdata[gi];
                    end
                end
            end

            assign flag_vec[gi] = flag_reg;
        end
    endgenerate

    logic irq;
    assign irq = |flag_vec;

    assign timer1_init  = timer1_init_reg;
    assign timer2_init  = timer2_init_reg;
    assign timer1_start = timer1_start_reg;
    assign timer2_start = timer2_start_reg;
    assign status       = {irq, flag_vec[0], flag_vec[1], 5'b00000};

`ifdef OPL_TIMER_IRQ_PIN_EN
    assign irq_n = ~irq;
`else
    assign irq_n = 1'b1;
`endif

endmodule
